// File: rtl/singular_buffer_if.sv
// Handshake bundle for singular_buffer: a four-phase producer port (dIn*)
// and a four-phase consumer port (dOut*).
// slave  : the buffer's view (accepts producer requests, raises consumer requests)
// master : the environment's view (drives producer data, acknowledges consumer side)
interface singular_buffer_if #(
  parameter int bit_width = 8
);
  logic                 dInREQ;
  logic                 dInACK;
  logic [bit_width-1:0] dIN;
  logic                 dOutREQ;
  logic                 dOutACK;
  logic [bit_width-1:0] dOUT;

  modport slave (
    input  dInREQ,
    output dInACK,
    input  dIN,
    output dOutREQ,
    input  dOutACK,
    output dOUT
  );

  modport master (
    output dInREQ,
    input  dInACK,
    output dIN,
    input  dOutREQ,
    output dOutACK,
    input  dOUT
  );
endinterface

// File: rtl/singular_buffer.sv
// Single-word buffer between two four-phase (return-to-zero) REQ/ACK ports.
//
// Input FSM
//   state    | meaning
//   IN_IDLE  | dInACK low, waiting for a request while the buffer is empty
//   IN_ACK   | word captured, dInACK high until the producer drops dInREQ
// Output FSM
//   state    | meaning
//   OUT_IDLE | dOutREQ low, waiting for a stored word and dOutACK low
//   OUT_REQ  | dOutREQ high, word offered to the consumer
//   OUT_WAIT | word consumed, waiting for dOutACK to return low
//
// Both FSMs share one register block because the full flag is set by the
// input side and cleared by the output side; the two can never touch it on
// the same edge (capture needs full=0, release happens only in OUT_REQ,
// which is only ever occupied while full=1).
module singular_buffer #(
  parameter int bit_width = 8
) (
  input  logic                clk,
  input  logic                rst,
  singular_buffer_if.slave    bus
);

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_WAIT
  } out_state_t;

  in_state_t            r_in_st;
  out_state_t           r_out_st;
  logic                 r_full;
  logic                 r_in_ack;
  logic                 r_out_req;
  logic [bit_width-1:0] r_data;

  logic w_capture;
  logic w_offer;

  // A capture happens only from IN_IDLE into an empty buffer; the offer
  // condition looks at the post-edge full value so dOutREQ can rise on the
  // capture edge itself.
  assign w_capture = (r_in_st == IN_IDLE) && bus.dInREQ && !r_full;
  assign w_offer   = (r_full || w_capture) && !bus.dOutACK;

  // Both handshake FSMs, the full flag and the storage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_st   <= IN_IDLE;
      r_out_st  <= OUT_IDLE;
      r_full    <= 1'b0;
      r_in_ack  <= 1'b0;
      r_out_req <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_in_st)
        IN_IDLE: begin
          if (w_capture) begin
            r_data   <= bus.dIN;
            r_full   <= 1'b1;
            r_in_ack <= 1'b1;
            r_in_st  <= IN_ACK;
          end
        end
        IN_ACK: begin
          if (!bus.dInREQ) begin
            r_in_ack <= 1'b0;
            r_in_st  <= IN_IDLE;
          end
        end
        default: begin
          r_in_ack <= 1'b0;
          r_in_st  <= IN_IDLE;
        end
      endcase

      case (r_out_st)
        OUT_IDLE: begin
          if (w_offer) begin
            r_out_req <= 1'b1;
            r_out_st  <= OUT_REQ;
          end
        end
        OUT_REQ: begin
          if (bus.dOutACK) begin
            r_full    <= 1'b0;
            r_out_req <= 1'b0;
            r_out_st  <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          if (!bus.dOutACK) begin
            r_out_st <= OUT_IDLE;
          end
        end
        default: begin
          r_out_req <= 1'b0;
          r_out_st  <= OUT_IDLE;
        end
      endcase
    end
  end

  assign bus.dInACK  = r_in_ack;
  assign bus.dOutREQ = r_out_req;
  assign bus.dOUT    = r_data;

endmodule

// File: tb/tb_singular_buffer.sv
// Directed bench for singular_buffer at bit_width=5: a vector table stepped
// one clock per entry, then hand-written sequences for the randomised
// back-to-back transfer and for reset in the middle of a handshake.
module tb_singular_buffer;

  localparam int W = 5;

  logic clk;
  logic rst;

  singular_buffer_if #(.bit_width(W)) sb ();

  singular_buffer #(.bit_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         req;
    logic         ack;
    logic [W-1:0] din;
    logic         e_inack;
    logic         e_outreq;
    logic [W-1:0] e_dout;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  logic [W-1:0] got [4];
  int           n_got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            req ack din    inack outreq dout
    tbl[0]  = '{1'b1, 1'b0, 5'h15, 1'b1, 1'b1, 5'h15}; // capture, one-cycle latency
    tbl[1]  = '{1'b0, 1'b0, 5'h0A, 1'b0, 1'b1, 5'h15}; // producer returns to zero
    tbl[2]  = '{1'b1, 1'b0, 5'h0A, 1'b0, 1'b1, 5'h15}; // full: held off
    tbl[3]  = '{1'b1, 1'b0, 5'h0A, 1'b0, 1'b1, 5'h15};
    tbl[4]  = '{1'b1, 1'b1, 5'h0A, 1'b0, 1'b0, 5'h15}; // consume, no same-edge capture
    tbl[5]  = '{1'b1, 1'b1, 5'h0A, 1'b1, 1'b0, 5'h0A}; // capture the edge after release
    tbl[6]  = '{1'b1, 1'b0, 5'h0A, 1'b1, 1'b0, 5'h0A}; // OUT_WAIT -> OUT_IDLE
    tbl[7]  = '{1'b0, 1'b0, 5'h0A, 1'b0, 1'b1, 5'h0A}; // offered
    tbl[8]  = '{1'b0, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h0A}; // consumed, dIN ignored
    tbl[9]  = '{1'b0, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h0A}; // ack outside OUT_REQ ignored
    tbl[10] = '{1'b1, 1'b0, 5'h07, 1'b1, 1'b0, 5'h07}; // capture while in OUT_WAIT
    tbl[11] = '{1'b1, 1'b1, 5'h07, 1'b1, 1'b0, 5'h07}; // no offer while ack high
    tbl[12] = '{1'b0, 1'b0, 5'h07, 1'b0, 1'b1, 5'h07};
    tbl[13] = '{1'b0, 1'b1, 5'h07, 1'b0, 1'b0, 5'h07};
    tbl[14] = '{1'b0, 1'b0, 5'h07, 1'b0, 1'b0, 5'h07};
    tbl[15] = '{1'b1, 1'b0, 5'h11, 1'b1, 1'b1, 5'h11};
    tbl[16] = '{1'b0, 1'b0, 5'h11, 1'b0, 1'b1, 5'h11};
    tbl[17] = '{1'b1, 1'b0, 5'h12, 1'b0, 1'b1, 5'h11}; // request while full
    tbl[18] = '{1'b0, 1'b0, 5'h12, 1'b0, 1'b1, 5'h11}; // withdrawn before capture
    tbl[19] = '{1'b0, 1'b1, 5'h12, 1'b0, 1'b0, 5'h11};
    tbl[20] = '{1'b0, 1'b0, 5'h12, 1'b0, 1'b0, 5'h11};
    tbl[21] = '{1'b0, 1'b0, 5'h12, 1'b0, 1'b0, 5'h11}; // withdrawn word never captured

    // Reset before any clock edge.
    rst        = 1'b0;
    sb.dInREQ  = 1'b0;
    sb.dOutACK = 1'b0;
    sb.dIN     = '0;
    #1;
    check("rst_inack",  32'(sb.dInACK),  32'h0);
    check("rst_outreq", 32'(sb.dOutREQ), 32'h0);
    check("rst_dout",   32'(sb.dOUT),    32'h0);
    #1;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      sb.dInREQ  = tbl[i].req;
      sb.dOutACK = tbl[i].ack;
      sb.dIN     = tbl[i].din;
      step();
      check($sformatf("vec%0d_inack", i),  32'(sb.dInACK),  32'(tbl[i].e_inack));
      check($sformatf("vec%0d_outreq", i), 32'(sb.dOutREQ), 32'(tbl[i].e_outreq));
      check($sformatf("vec%0d_dout", i),   32'(sb.dOUT),    32'(tbl[i].e_dout));
    end

    // Back-to-back words with random return-to-zero delays on both sides.
    n_got = 0;
    fork
      begin : producer
        int tmo;
        for (int w = 1; w <= 4; w++) begin
          sb.dIN    = 5'(w);
          sb.dInREQ = 1'b1;
          tmo = 0;
          while (!sb.dInACK && tmo < 50) begin step(); tmo++; end
          check($sformatf("b2b_prod_ack_hi_w%0d", w), 32'(sb.dInACK), 32'h1);
          repeat ($urandom_range(0, 3)) step();
          sb.dInREQ = 1'b0;
          tmo = 0;
          while (sb.dInACK && tmo < 50) begin step(); tmo++; end
          check($sformatf("b2b_prod_ack_lo_w%0d", w), 32'(sb.dInACK), 32'h0);
          repeat ($urandom_range(0, 3)) step();
        end
      end
      begin : consumer
        int tmo;
        for (int k = 0; k < 4; k++) begin
          tmo = 0;
          while (!sb.dOutREQ && tmo < 50) begin step(); tmo++; end
          check($sformatf("b2b_cons_req_hi_%0d", k), 32'(sb.dOutREQ), 32'h1);
          got[k] = sb.dOUT;
          n_got++;
          repeat ($urandom_range(0, 3)) step();
          sb.dOutACK = 1'b1;
          tmo = 0;
          while (sb.dOutREQ && tmo < 50) begin step(); tmo++; end
          check($sformatf("b2b_cons_req_lo_%0d", k), 32'(sb.dOutREQ), 32'h0);
          repeat ($urandom_range(0, 3)) step();
          sb.dOutACK = 1'b0;
        end
      end
    join
    check("b2b_count", 32'(n_got), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("b2b_word%0d", k), 32'(got[k]), 32'(k + 1));
    repeat (4) step();
    check("b2b_no_duplicate", 32'(sb.dOutREQ), 32'h0);

    // Reset while a word is being offered.
    sb.dIN     = 5'h1B;
    sb.dInREQ  = 1'b1;
    sb.dOutACK = 1'b0;
    step();
    check("mid_pre_outreq", 32'(sb.dOutREQ), 32'h1);
    check("mid_pre_dout",   32'(sb.dOUT),    32'h1B);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_inack",  32'(sb.dInACK),  32'h0);
    check("mid_rst_outreq", 32'(sb.dOutREQ), 32'h0);
    check("mid_rst_dout",   32'(sb.dOUT),    32'h0);
    step();
    check("mid_rst_hold_inack", 32'(sb.dInACK), 32'h0);
    check("mid_rst_hold_dout",  32'(sb.dOUT),   32'h0);
    sb.dIN = 5'h0C;
    rst    = 1'b1;
    step();
    check("post_rst_inack",  32'(sb.dInACK),  32'h1);
    check("post_rst_outreq", 32'(sb.dOutREQ), 32'h1);
    check("post_rst_dout",   32'(sb.dOUT),    32'h0C);
    sb.dInREQ  = 1'b0;
    sb.dOutACK = 1'b1;
    step();
    check("post_rst_done_inack",  32'(sb.dInACK),  32'h0);
    check("post_rst_done_outreq", 32'(sb.dOutREQ), 32'h0);
    check("post_rst_done_dout",   32'(sb.dOUT),    32'h0C);
    sb.dOutACK = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
